// File: rtl/rtlmem_1rwnx_be.sv
// Single-port RAM with per-lane write enables, G_LAT-deep registered read path
// and a clear engine that sweeps G_RST_VAL through the array one entry per cycle.
module rtlmem_1rwnx_be #(
    parameter int                 G_ADDR       = 10,
    parameter int                 G_DEPTH      = 2**G_ADDR,
    parameter int                 G_WIDTH      = 32,
    parameter int                 G_LANE       = 8,
    parameter int                 G_LAT        = 1,
    parameter logic [G_WIDTH-1:0] G_RST_VAL    = '0,
    parameter bit                 G_CLR_ON_RST = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clren,
    output logic                       clrrdy,
    input  logic [G_ADDR-1:0]          memad,
    input  logic [G_WIDTH/G_LANE-1:0]  memwe,
    input  logic [G_WIDTH-1:0]         memdi,
    input  logic                       memre,
    output logic [G_WIDTH-1:0]         memdo,
    output logic                       memdv,
    output logic                       memdrop
);

    localparam int                NBE     = G_WIDTH / G_LANE;
    localparam logic [G_ADDR:0]   DEPTH_C = (G_ADDR+1)'(G_DEPTH);
    localparam logic [G_ADDR-1:0] LAST_C  = G_ADDR'(G_DEPTH - 1);

    typedef enum logic {S_IDLE, S_CLEAR} state_t;

    state_t            state_q, state_d;
    logic [G_ADDR-1:0] cnt_q, cnt_d;

    logic [G_WIDTH-1:0] mem [0:G_DEPTH-1];

    logic               idle, usr_acc, in_rng, rd_acc;
    logic [G_WIDTH-1:0] rd_raw, rd_word;
    logic [G_LAT-1:0]   vld_pipe_q;
    logic [G_WIDTH-1:0] dat_q [G_LAT];
    logic               drop_q;

    assign idle    = (state_q == S_IDLE);
    assign usr_acc = memre | (|memwe);
    assign in_rng  = ({1'b0, memad} < DEPTH_C);
    assign rd_acc  = idle & memre;
    assign rd_raw  = in_rng ? mem[memad] : '0;

    // Write-first: the read sees the word as it will look after this cycle's lane writes.
    always_comb begin
        rd_word = rd_raw;
        for (int i = 0; i < NBE; i++)
            if (memwe[i]) rd_word[i*G_LANE +: G_LANE] = memdi[i*G_LANE +: G_LANE];
        if (!in_rng) rd_word = G_RST_VAL;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE:  if (clren) state_d = S_CLEAR;
            S_CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_C) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= G_CLR_ON_RST ? S_CLEAR : S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Array contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (!idle) begin
            mem[cnt_q] <= G_RST_VAL;
        end else if (in_rng) begin
            for (int i = 0; i < NBE; i++)
                if (memwe[i]) mem[memad][i*G_LANE +: G_LANE] <= memdi[i*G_LANE +: G_LANE];
        end
    end

    // Data stages only load behind a valid, so the last stage holds memdo between reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe_q <= '0;
            drop_q     <= 1'b0;
            for (int i = 0; i < G_LAT; i++) dat_q[i] <= '0;
        end else begin
            vld_pipe_q[0] <= rd_acc;
            if (rd_acc) dat_q[0] <= rd_word;
            for (int i = 1; i < G_LAT; i++) begin
                vld_pipe_q[i] <= vld_pipe_q[i-1];
                if (vld_pipe_q[i-1]) dat_q[i] <= dat_q[i-1];
            end
            drop_q <= usr_acc & (~idle | ~in_rng);
        end
    end

    assign clrrdy  = idle;
    assign memdo   = dat_q[G_LAT-1];
    assign memdv   = vld_pipe_q[G_LAT-1];
    assign memdrop = drop_q;

endmodule
